// File: rtl/hm2_gpio_pkg.sv
// Shared constants and helpers for the HostMot2 GPIO bank mux.
//   - Board-level defaults for header count, header width and hm2 I/O count
//   - Per-header register offsets (bus_addr[2:0])
//   - mux_width(): hm2 pins carried by each header
//   - params_ok(): elaboration-time sanity check of a parameter set
package hm2_gpio_pkg;

   localparam int BOARD_NUM_GPIO   = 2;
   localparam int BOARD_GPIO_WIDTH = 36;
   localparam int BOARD_IO_WIDTH   = 72;
   localparam int BUS_WIDTH        = 32;

   localparam logic [2:0] REG_FILT      = 3'd0;
   localparam logic [2:0] REG_STATE_LO  = 3'd1;
   localparam logic [2:0] REG_STATE_HI  = 3'd2;
   localparam logic [2:0] REG_CHG_LO    = 3'd3;
   localparam logic [2:0] REG_CHG_HI    = 3'd4;
   localparam logic [2:0] REG_SPARE_OUT = 3'd5;
   localparam logic [2:0] REG_SPARE_OE  = 3'd6;

   function automatic int mux_width(input int io_width, input int num_gpio);
      return io_width / num_gpio;
   endfunction

   function automatic bit params_ok(input int num_gpio, input int gpio_width,
                                    input int io_width, input int bus_width,
                                    input int filt_bits);
      return (num_gpio >= 1) && (num_gpio <= 8) &&
             (io_width % num_gpio == 0) &&
             (mux_width(io_width, num_gpio) >= 1) &&
             (mux_width(io_width, num_gpio) <= gpio_width) &&
             (gpio_width <= 64) && (bus_width == 32) &&
             (filt_bits >= 1) && (filt_bits <= 32);
   endfunction

endpackage

// File: rtl/hm2_gpio_filter_bit.sv
// One pad input: 2-FF synchroniser followed by a glitch filter.
//   clklow, reset_n : clock, synchronous active-low reset
//   pad             : raw pad input (asynchronous to clklow)
//   filt_len        : filter length L; a level must persist L+1 synced cycles
//   load_clr        : clears the persistence counter (header FILT write)
//   filt            : filtered level
//   toggle          : high in the cycle filt is about to change
module hm2_gpio_filter_bit
   import hm2_gpio_pkg::*;
#(
   parameter int FiltBits = 8
) (
   input  logic                clklow,
   input  logic                reset_n,
   input  logic                pad,
   input  logic [FiltBits-1:0] filt_len,
   input  logic                load_clr,
   output logic                filt,
   output logic                toggle
);

   logic                sync_1;
   logic                sync_2;
   logic [FiltBits-1:0] cnt;

   // A FILT write restarts the count, so the filter never commits in that cycle.
   assign toggle = !load_clr && (sync_2 != filt) && (cnt == filt_len);

   always_ff @(posedge clklow) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         filt   <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_1 <= pad;
         sync_2 <= sync_1;
         if (load_clr) begin
            cnt <= '0;
         end else if (sync_2 == filt) begin
            cnt <= '0;
         end else if (cnt == filt_len) begin
            filt <= sync_2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hm2_gpio_bank_mux.sv
// Maps IOWidth HostMot2 pins onto NumGPIO headers of GPIOWidth pins each.
//   clklow, reset_n       : bus clock, synchronous active-low reset
//   hm2_out/hm2_oe        : HostMot2 output data/enables -> gpio_out/gpio_oe (1 cycle)
//   hm2_in                : filtered pad levels back to HostMot2
//   gpio_in/out/oe        : header pads, header h occupies bits h*GPIOWidth +: GPIOWidth
//   bus_addr[5:3]/[2:0]   : header / register select
//   bus_wr, bus_rd        : strobes; read data returns next cycle with bus_rvalid
// Header pins at or above MuxWidth are spares driven from SPARE_OUT/SPARE_OE.
module hm2_gpio_bank_mux
   import hm2_gpio_pkg::*;
#(
   parameter int NumGPIO     = BOARD_NUM_GPIO,
   parameter int GPIOWidth   = BOARD_GPIO_WIDTH,
   parameter int IOWidth     = BOARD_IO_WIDTH,
   parameter int FiltBits    = 8,
   parameter int FiltDefault = 0,
   parameter int BusWidth    = BUS_WIDTH
) (
   input  logic                           clklow,
   input  logic                           reset_n,
   input  logic [IOWidth-1:0]             hm2_out,
   input  logic [IOWidth-1:0]             hm2_oe,
   output logic [IOWidth-1:0]             hm2_in,
   input  logic [NumGPIO*GPIOWidth-1:0]   gpio_in,
   output logic [NumGPIO*GPIOWidth-1:0]   gpio_out,
   output logic [NumGPIO*GPIOWidth-1:0]   gpio_oe,
   input  logic [5:0]                     bus_addr,
   input  logic                           bus_wr,
   input  logic                           bus_rd,
   input  logic [BusWidth-1:0]            bus_wdata,
   output logic [BusWidth-1:0]            bus_rdata,
   output logic                           bus_rvalid
);

   localparam int MuxWidth   = mux_width(IOWidth, NumGPIO);
   localparam int SpareWidth = GPIOWidth - MuxWidth;
   localparam int SpareBits  = (SpareWidth > 32) ? 32 : SpareWidth;
   localparam logic [31:0] SPARE_MASK = 32'hFFFF_FFFF >> (32 - SpareBits);

   if (!params_ok(NumGPIO, GPIOWidth, IOWidth, BusWidth, FiltBits)) begin : g_bad_params
      $error("hm2_gpio_bank_mux: unsupported NumGPIO/GPIOWidth/IOWidth/BusWidth/FiltBits");
   end

   logic [2:0] hdr_sel;
   logic [2:0] reg_sel;
   assign hdr_sel = bus_addr[5:3];
   assign reg_sel = bus_addr[2:0];

   logic [NumGPIO-1:0]                wr_hit;
   logic [NumGPIO-1:0]                load_clr;
   logic [NumGPIO-1:0][FiltBits-1:0]  filt_len_q;
   logic [NumGPIO-1:0][31:0]          spare_out_q;
   logic [NumGPIO-1:0][31:0]          spare_oe_q;
   logic [NumGPIO-1:0][GPIOWidth-1:0] filt_q;
   logic [NumGPIO-1:0][GPIOWidth-1:0] toggle;
   logic [NumGPIO-1:0][GPIOWidth-1:0] chg_q;
   logic [NumGPIO-1:0][GPIOWidth-1:0] chg_clr;
   logic [NumGPIO-1:0][63:0]          state_ext;
   logic [NumGPIO-1:0][63:0]          chg_ext;
   logic [NumGPIO*GPIOWidth-1:0]      out_nxt;
   logic [NumGPIO*GPIOWidth-1:0]      oe_nxt;
   logic [31:0]                       rd_mux;

   // Header selects above NumGPIO-1 never match, so those writes fall away.
   always_comb begin
      wr_hit   = '0;
      load_clr = '0;
      for (int h = 0; h < NumGPIO; h++) begin
         wr_hit[h]   = bus_wr && (hdr_sel == 3'(h));
         load_clr[h] = wr_hit[h] && (reg_sel == REG_FILT);
      end
   end

   always_ff @(posedge clklow) begin
      if (!reset_n) begin
         for (int h = 0; h < NumGPIO; h++) begin
            filt_len_q[h]  <= FiltBits'(FiltDefault);
            spare_out_q[h] <= '0;
            spare_oe_q[h]  <= '0;
         end
      end else begin
         for (int h = 0; h < NumGPIO; h++) begin
            if (wr_hit[h]) begin
               case (reg_sel)
                  REG_FILT:      filt_len_q[h]  <= bus_wdata[FiltBits-1:0];
                  REG_SPARE_OUT: spare_out_q[h] <= bus_wdata & SPARE_MASK;
                  REG_SPARE_OE:  spare_oe_q[h]  <= bus_wdata & SPARE_MASK;
                  default:       ;
               endcase
            end
         end
      end
   end

   for (genvar h = 0; h < NumGPIO; h++) begin : g_hdr
      assign state_ext[h] = 64'(filt_q[h]);
      assign chg_ext[h]   = 64'(chg_q[h]);

      for (genvar p = 0; p < GPIOWidth; p++) begin : g_pin
         hm2_gpio_filter_bit #(.FiltBits(FiltBits)) u_filter_bit (
            .clklow   (clklow),
            .reset_n  (reset_n),
            .pad      (gpio_in[h*GPIOWidth+p]),
            .filt_len (filt_len_q[h]),
            .load_clr (load_clr[h]),
            .filt     (filt_q[h][p]),
            .toggle   (toggle[h][p])
         );

         assign chg_clr[h][p] = wr_hit[h] && bus_wdata[p % 32] &&
                                (reg_sel == ((p < 32) ? REG_CHG_LO : REG_CHG_HI));

         if (p < MuxWidth) begin : g_mapped
            assign out_nxt[h*GPIOWidth+p] = hm2_out[h*MuxWidth+p];
            assign oe_nxt[h*GPIOWidth+p]  = hm2_oe[h*MuxWidth+p];
            assign hm2_in[h*MuxWidth+p]   = filt_q[h][p];
         end else if (p - MuxWidth < 32) begin : g_spare
            assign out_nxt[h*GPIOWidth+p] = spare_out_q[h][p-MuxWidth];
            assign oe_nxt[h*GPIOWidth+p]  = spare_oe_q[h][p-MuxWidth];
         end else begin : g_idle
            assign out_nxt[h*GPIOWidth+p] = 1'b0;
            assign oe_nxt[h*GPIOWidth+p]  = 1'b0;
         end
      end
   end

   // Set beats clear so a toggle coinciding with a W1C write is never lost.
   always_ff @(posedge clklow) begin
      if (!reset_n) begin
         chg_q <= '0;
      end else begin
         for (int h = 0; h < NumGPIO; h++) begin
            chg_q[h] <= (chg_q[h] & ~chg_clr[h]) | toggle[h];
         end
      end
   end

   always_ff @(posedge clklow) begin
      if (!reset_n) begin
         gpio_out <= '0;
         gpio_oe  <= '0;
      end else begin
         gpio_out <= out_nxt;
         gpio_oe  <= oe_nxt;
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int h = 0; h < NumGPIO; h++) begin
         if (hdr_sel == 3'(h)) begin
            case (reg_sel)
               REG_FILT:      rd_mux = 32'(filt_len_q[h]);
               REG_STATE_LO:  rd_mux = state_ext[h][31:0];
               REG_STATE_HI:  rd_mux = state_ext[h][63:32];
               REG_CHG_LO:    rd_mux = chg_ext[h][31:0];
               REG_CHG_HI:    rd_mux = chg_ext[h][63:32];
               REG_SPARE_OUT: rd_mux = spare_out_q[h];
               REG_SPARE_OE:  rd_mux = spare_oe_q[h];
               default:       rd_mux = '0;
            endcase
         end
      end
   end

   // Read data is captured from the pre-write register state.
   always_ff @(posedge clklow) begin
      if (!reset_n) begin
         bus_rdata  <= '0;
         bus_rvalid <= 1'b0;
      end else begin
         bus_rvalid <= bus_rd;
         if (bus_rd) begin
            bus_rdata <= rd_mux;
         end
      end
   end

endmodule
